position_cache_array: RTL and testbench
=======================================

Name: position_cache_array

Overview:
Parametrised, double-buffered array of per-cell position caches for an X_DIM x Y_DIM x Z_DIM cell grid.
- The force pipeline reads the active bank of every cell in parallel.
- Motion update appends new positions into the shadow bank of a destination cell.
- A swap handshake atomically promotes the shadow banks to active at the end of a timestep.
- The block sits between the motion-update unit and the force-evaluation pipelines.

Parameters:
X_DIM, 5, cells along x
Y_DIM, 5, cells along y
Z_DIM, 5, cells along z
NUM_CELLS, X_DIM*Y_DIM*Z_DIM, derived; do not override
OFFSET_WIDTH, 29, width of one axis offset
POS_WIDTH, 3*OFFSET_WIDTH, width of one packed position {x,y,z}
CELL_ID_WIDTH, 3, width of each 1-based cell coordinate
NUM_PARTICLE_PER_CELL, 128, depth of each bank
PARTICLE_ID_WIDTH, 7, clog2(NUM_PARTICLE_PER_CELL)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_en  in  1  force-pipeline read strobe
rd_addr  in  PARTICLE_ID_WIDTH  common read address applied to all cells
pos_data_out  out  NUM_CELLS*POS_WIDTH  per-cell active-bank data; cell n at slice n
pos_valid_out  out  NUM_CELLS  per-cell flag: rd_addr < active count
MU_rden  in  1  motion-update read strobe
MU_rd_cell  in  3*CELL_ID_WIDTH  {x,y,z} cell coordinates, 1-based
MU_rd_addr  in  PARTICLE_ID_WIDTH  MU read address
MU_rd_data  out  POS_WIDTH  MU read data
MU_rd_valid  out  1  MU read data valid
MU_wr_data_valid  in  1  write request
MU_wr_ready  out  1  write accepted this cycle
MU_wr_data  in  POS_WIDTH  position to append
MU_dst_cell  in  3*CELL_ID_WIDTH  {x,y,z} destination cell, 1-based
swap_req  in  1  end-of-timestep swap request pulse
swap_busy  out  1  swap in progress
swap_done  out  1  one-cycle pulse when swap completes
overflow  out  NUM_CELLS  sticky per-cell overflow flag
bad_cell_err  out  1  one-cycle pulse: MU access addressed an out-of-range cell

Behaviour:
- Cell index: linear = ((x-1)*Y_DIM + (y-1))*Z_DIM + (z-1). A coordinate equal to 0 or greater than its DIM is invalid.
- Storage per cell: two banks, shared bank_sel (active = bank_sel, shadow = ~bank_sel), active_count and shadow_count (PARTICLE_ID_WIDTH+1 bits each). RAM contents are not reset.
- Reset: bank_sel=0; all counts 0; pos_data_out=0; pos_valid_out=0; MU_rd_data=0; MU_rd_valid=0; swap_busy=0; swap_done=0; overflow=0; bad_cell_err=0; MU_wr_ready=1. Reset mid-swap returns the block to IDLE with bank_sel=0.
- Force read: rd_en at cycle t registers data at t+1.
  - pos_valid_out[n] = (rd_addr < active_count[n]).
  - An invalid slot outputs zero data.
  - Without rd_en, outputs hold their previous values.
- MU read: MU_rden at cycle t, valid cell -> MU_rd_data/MU_rd_valid at t+1. Valid requires address < active_count, otherwise data=0 and valid=0. An invalid cell gives valid=0 plus a bad_cell_err pulse at t+1.
- MU write: accepted when MU_wr_data_valid && MU_wr_ready.
  - Data is written to shadow bank[shadow_count] of the target cell, then shadow_count increments.
  - Target cell full (shadow_count == NUM_PARTICLE_PER_CELL): write dropped, overflow[n] set.
  - Invalid cell: write dropped, bad_cell_err pulses next cycle.
- FSM IDLE / SWAP / DONE:
  - IDLE: MU_wr_ready=1. swap_req -> SWAP. A write accepted in the same cycle as swap_req lands in the old shadow bank and is counted.
  - SWAP (1 cycle): MU_wr_ready=0, swap_busy=1. Flip bank_sel; active_count <= shadow_count; shadow_count <= 0; overflow cleared. -> DONE.
  - DONE (1 cycle): swap_done=1, swap_busy=1, MU_wr_ready=0 -> IDLE.
  - swap_req outside IDLE is ignored.
- Reads during SWAP return old-bank data. Reads issued in DONE or later return new-bank data.
- Simultaneous MU read and write to the same cell never conflict, because they target different banks.

Test Plan:
- Reset, then rd_en with rd_addr=0 -> all pos_valid_out=0, pos_data_out=0; MU_wr_ready=1.
- Write 3 positions (0x1,0x2,0x3) to cell (1,1,1), then swap_req -> swap_done exactly 2 cycles later. Next, rd_addr=0..3 -> cell 0 returns 0x1,0x2,0x3 with valid=1, then 0 with valid=0. All other cells valid=0.
- Write 130 entries to cell (5,5,5), default params -> first 128 stored, overflow[124]=1. After swap, overflow[124]=0 and active_count=128.
- Write to cell (0,2,2) and to cell (6,1,1) -> both dropped, bad_cell_err pulses once each, counts unchanged.
- Write to cell (2,3,4) in the same cycle as swap_req -> entry visible after swap. A write asserted during SWAP/DONE sees MU_wr_ready=0 and lands only after return to IDLE, i.e. after the next swap.
- Assert rst while in SWAP -> FSM in IDLE, bank_sel=0, counts 0; re-run with X_DIM=3, Y_DIM=4, Z_DIM=2 and write to cell (3,4,2) -> cell index 23 holds the data.

Source files
------------

// File: rtl/position_cache_array.sv
// Double-buffered per-cell position caches: force pipelines read every cell's active bank in
// parallel while motion update appends into the shadow bank; a swap promotes shadow to active.
module position_cache_array #(
  parameter int X_DIM                 = 5,
  parameter int Y_DIM                 = 5,
  parameter int Z_DIM                 = 5,
  parameter int NUM_CELLS             = X_DIM*Y_DIM*Z_DIM,  // derived; do not override
  parameter int OFFSET_WIDTH          = 29,
  parameter int POS_WIDTH             = 3*OFFSET_WIDTH,
  parameter int CELL_ID_WIDTH         = 3,
  parameter int NUM_PARTICLE_PER_CELL = 128,
  parameter int PARTICLE_ID_WIDTH     = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [PARTICLE_ID_WIDTH-1:0]      rd_addr,
  output logic [NUM_CELLS*POS_WIDTH-1:0]    pos_data_out,
  output logic [NUM_CELLS-1:0]              pos_valid_out,
  input  logic                              MU_rden,
  input  logic [3*CELL_ID_WIDTH-1:0]        MU_rd_cell,
  input  logic [PARTICLE_ID_WIDTH-1:0]      MU_rd_addr,
  output logic [POS_WIDTH-1:0]              MU_rd_data,
  output logic                              MU_rd_valid,
  input  logic                              MU_wr_data_valid,
  output logic                              MU_wr_ready,
  input  logic [POS_WIDTH-1:0]              MU_wr_data,
  input  logic [3*CELL_ID_WIDTH-1:0]        MU_dst_cell,
  input  logic                              swap_req,
  output logic                              swap_busy,
  output logic                              swap_done,
  output logic [NUM_CELLS-1:0]              overflow,
  output logic                              bad_cell_err
);

  localparam int CW     = CELL_ID_WIDTH;
  localparam int CNT_W  = PARTICLE_ID_WIDTH + 1;
  localparam int CIDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SWAP, S_DONE} state_e;

  state_e                 state_q;
  logic                   bank_sel_q;
  logic [CNT_W-1:0]       act_cnt_q [NUM_CELLS];
  logic [CNT_W-1:0]       shd_cnt_q [NUM_CELLS];
  logic [POS_WIDTH-1:0]   mem_q     [NUM_CELLS][2*NUM_PARTICLE_PER_CELL];

  function automatic logic cell_ok(input logic [3*CW-1:0] c);
    int x, y, z;
    x = int'(c[3*CW-1:2*CW]);
    y = int'(c[2*CW-1:CW]);
    z = int'(c[CW-1:0]);
    return (x >= 1) && (x <= X_DIM) && (y >= 1) && (y <= Y_DIM) && (z >= 1) && (z <= Z_DIM);
  endfunction

  function automatic logic [CIDX_W-1:0] cell_idx(input logic [3*CW-1:0] c);
    int lin;
    lin = ((int'(c[3*CW-1:2*CW]) - 1) * Y_DIM + (int'(c[2*CW-1:CW]) - 1)) * Z_DIM
          + (int'(c[CW-1:0]) - 1);
    return CIDX_W'(lin);
  endfunction

  logic              wr_ok, rd_ok, wr_fire, wr_room, wr_store;
  logic [CIDX_W-1:0] wr_idx, rd_idx;

  always_comb begin
    wr_ok    = cell_ok(MU_dst_cell);
    wr_idx   = cell_idx(MU_dst_cell);
    rd_ok    = cell_ok(MU_rd_cell);
    rd_idx   = cell_idx(MU_rd_cell);
    wr_fire  = MU_wr_data_valid && MU_wr_ready;
    wr_room  = shd_cnt_q[wr_idx] < CNT_W'(NUM_PARTICLE_PER_CELL);
    wr_store = wr_fire && wr_ok && wr_room;
  end

  // Writes only fire in IDLE, so bank_sel is stable while the shadow bank is being filled.
  always_ff @(posedge clk) begin
    if (wr_store)
      mem_q[wr_idx][{~bank_sel_q, shd_cnt_q[wr_idx][PARTICLE_ID_WIDTH-1:0]}] <= MU_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bank_sel_q   <= 1'b0;
      MU_wr_ready  <= 1'b1;
      swap_busy    <= 1'b0;
      swap_done    <= 1'b0;
      overflow     <= '0;
      bad_cell_err <= 1'b0;
      for (int n = 0; n < NUM_CELLS; n++) begin
        act_cnt_q[n] <= '0;
        shd_cnt_q[n] <= '0;
      end
    end else begin
      bad_cell_err <= (MU_rden && !rd_ok) || (wr_fire && !wr_ok);
      if (wr_store)
        shd_cnt_q[wr_idx] <= shd_cnt_q[wr_idx] + CNT_W'(1);
      if (wr_fire && wr_ok && !wr_room)
        overflow[wr_idx] <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (swap_req) begin
            state_q     <= S_SWAP;
            MU_wr_ready <= 1'b0;
            swap_busy   <= 1'b1;
          end
        end
        S_SWAP: begin
          state_q    <= S_DONE;
          swap_done  <= 1'b1;
          bank_sel_q <= ~bank_sel_q;
          overflow   <= '0;
          for (int n = 0; n < NUM_CELLS; n++) begin
            act_cnt_q[n] <= shd_cnt_q[n];
            shd_cnt_q[n] <= '0;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          swap_done   <= 1'b0;
          swap_busy   <= 1'b0;
          MU_wr_ready <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read ports see bank_sel/active counts before the SWAP edge, so reads in SWAP hit the old bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_data_out  <= '0;
      pos_valid_out <= '0;
      MU_rd_data    <= '0;
      MU_rd_valid   <= 1'b0;
    end else begin
      if (rd_en) begin
        for (int n = 0; n < NUM_CELLS; n++) begin
          if ({1'b0, rd_addr} < act_cnt_q[n]) begin
            pos_valid_out[n]                     <= 1'b1;
            pos_data_out[n*POS_WIDTH +: POS_WIDTH] <= mem_q[n][{bank_sel_q, rd_addr}];
          end else begin
            pos_valid_out[n]                     <= 1'b0;
            pos_data_out[n*POS_WIDTH +: POS_WIDTH] <= '0;
          end
        end
      end
      if (MU_rden && rd_ok && ({1'b0, MU_rd_addr} < act_cnt_q[rd_idx])) begin
        MU_rd_data  <= mem_q[rd_idx][{bank_sel_q, MU_rd_addr}];
        MU_rd_valid <= 1'b1;
      end else begin
        if (MU_rden)
          MU_rd_data <= '0;
        MU_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_position_cache_array.sv
// Directed plus randomized bench for position_cache_array against a queue-based cell model.
module tb_position_cache_array;

  localparam int X = 5, Y = 5, Z = 5, NC = X*Y*Z;
  localparam int SX = 3, SY = 4, SZ = 2, SNC = SX*SY*SZ;
  localparam int PW = 87, PIDW = 7, NPC = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-size instance
  logic              rd_en, MU_rden, MU_wr_data_valid, swap_req;
  logic [PIDW-1:0]   rd_addr, MU_rd_addr;
  logic [NC*PW-1:0]  pos_data_out;
  logic [NC-1:0]     pos_valid_out, overflow;
  logic [8:0]        MU_rd_cell, MU_dst_cell;
  logic [PW-1:0]     MU_rd_data, MU_wr_data;
  logic              MU_rd_valid, MU_wr_ready, swap_busy, swap_done, bad_cell_err;

  position_cache_array u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .pos_data_out(pos_data_out), .pos_valid_out(pos_valid_out),
    .MU_rden(MU_rden), .MU_rd_cell(MU_rd_cell), .MU_rd_addr(MU_rd_addr),
    .MU_rd_data(MU_rd_data), .MU_rd_valid(MU_rd_valid),
    .MU_wr_data_valid(MU_wr_data_valid), .MU_wr_ready(MU_wr_ready),
    .MU_wr_data(MU_wr_data), .MU_dst_cell(MU_dst_cell),
    .swap_req(swap_req), .swap_busy(swap_busy), .swap_done(swap_done),
    .overflow(overflow), .bad_cell_err(bad_cell_err)
  );

  // Small-grid instance
  logic              s_rd_en, s_MU_rden, s_MU_wr_data_valid, s_swap_req;
  logic [PIDW-1:0]   s_rd_addr, s_MU_rd_addr;
  logic [SNC*PW-1:0] s_pos_data_out;
  logic [SNC-1:0]    s_pos_valid_out, s_overflow;
  logic [8:0]        s_MU_rd_cell, s_MU_dst_cell;
  logic [PW-1:0]     s_MU_rd_data, s_MU_wr_data;
  logic              s_MU_rd_valid, s_MU_wr_ready, s_swap_busy, s_swap_done, s_bad_cell_err;

  position_cache_array #(.X_DIM(SX), .Y_DIM(SY), .Z_DIM(SZ)) u_dut_small (
    .clk(clk), .rst(rst), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .pos_data_out(s_pos_data_out), .pos_valid_out(s_pos_valid_out),
    .MU_rden(s_MU_rden), .MU_rd_cell(s_MU_rd_cell), .MU_rd_addr(s_MU_rd_addr),
    .MU_rd_data(s_MU_rd_data), .MU_rd_valid(s_MU_rd_valid),
    .MU_wr_data_valid(s_MU_wr_data_valid), .MU_wr_ready(s_MU_wr_ready),
    .MU_wr_data(s_MU_wr_data), .MU_dst_cell(s_MU_dst_cell),
    .swap_req(s_swap_req), .swap_busy(s_swap_busy), .swap_done(s_swap_done),
    .overflow(s_overflow), .bad_cell_err(s_bad_cell_err)
  );

  // Reference model: per-cell active/shadow contents as queues
  logic [PW-1:0] act_m [NC][$];
  logic [PW-1:0] shd_m [NC][$];
  logic [NC-1:0] ovf_m;

  int checks = 0;
  int failures = 0;

  function automatic int model_idx(input int x, y, z, dx, dy, dz);
    if (x < 1 || x > dx || y < 1 || y > dy || z < 1 || z > dz) return -1;
    return ((x - 1) * dy + (y - 1)) * dz + (z - 1);
  endfunction

  function automatic logic [PW-1:0] rand_pos();
    return PW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int n = 0; n < NC; n++) begin
      act_m[n].delete();
      shd_m[n].delete();
    end
    ovf_m = '0;
  endtask

  task automatic model_push(input int idx, input logic [PW-1:0] d);
    if (idx < 0) return;
    if (shd_m[idx].size() < NPC) shd_m[idx].push_back(d);
    else ovf_m[idx] = 1'b1;
  endtask

  task automatic model_promote();
    for (int n = 0; n < NC; n++) begin
      act_m[n] = shd_m[n];
      shd_m[n].delete();
    end
    ovf_m = '0;
  endtask

  task automatic do_write(input int x, y, z, input logic [PW-1:0] d);
    int idx;
    idx = model_idx(x, y, z, X, Y, Z);
    MU_dst_cell = {3'(x), 3'(y), 3'(z)};
    MU_wr_data = d;
    MU_wr_data_valid = 1'b1;
    chk("wr_ready", MU_wr_ready, 1);
    step();
    MU_wr_data_valid = 1'b0;
    model_push(idx, d);
    chk("wr_bad_cell_err", bad_cell_err, idx < 0);
  endtask

  task automatic do_swap(input bit wr_same, input int x, y, z, input logic [PW-1:0] d);
    if (wr_same) begin
      MU_dst_cell = {3'(x), 3'(y), 3'(z)};
      MU_wr_data = d;
      MU_wr_data_valid = 1'b1;
    end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    MU_wr_data_valid = 1'b0;
    if (wr_same) model_push(model_idx(x, y, z, X, Y, Z), d);
    chk("swap_state_busy", swap_busy, 1);
    chk("swap_state_ready", MU_wr_ready, 0);
    chk("swap_state_done", swap_done, 0);
    model_promote();
    step();
    chk("done_state_done", swap_done, 1);
    chk("done_state_busy", swap_busy, 1);
    step();
    chk("idle_done", swap_done, 0);
    chk("idle_busy", swap_busy, 0);
    chk("idle_ready", MU_wr_ready, 1);
  endtask

  task automatic force_read(input int addr);
    logic [NC-1:0] ev;
    logic [PW-1:0] ed;
    rd_en = 1'b1;
    rd_addr = PIDW'(addr);
    step();
    rd_en = 1'b0;
    for (int n = 0; n < NC; n++) begin
      ev[n] = addr < act_m[n].size();
      ed = '0;
      if (ev[n]) ed = act_m[n][addr];
      chk($sformatf("pos_data_c%0d_a%0d", n, addr), pos_data_out[n*PW +: PW], ed);
    end
    chk($sformatf("pos_valid_a%0d", addr), pos_valid_out, ev);
  endtask

  task automatic mu_read(input int x, y, z, addr);
    int idx;
    logic ev;
    logic [PW-1:0] ed;
    idx = model_idx(x, y, z, X, Y, Z);
    MU_rd_cell = {3'(x), 3'(y), 3'(z)};
    MU_rd_addr = PIDW'(addr);
    MU_rden = 1'b1;
    step();
    MU_rden = 1'b0;
    ev = (idx >= 0) && (addr < act_m[idx].size());
    ed = '0;
    if (ev) ed = act_m[idx][addr];
    chk("mu_rd_valid", MU_rd_valid, ev);
    chk("mu_rd_data", MU_rd_data, ed);
    chk("mu_rd_bad_cell_err", bad_cell_err, idx < 0);
  endtask

  // Same-cell MU read and write in one cycle: read sees active bank, write lands in shadow.
  task automatic rw_same(input int x, y, z, input logic [PW-1:0] d);
    int idx;
    logic ev;
    logic [PW-1:0] ed;
    idx = model_idx(x, y, z, X, Y, Z);
    MU_rd_cell = {3'(x), 3'(y), 3'(z)};
    MU_dst_cell = {3'(x), 3'(y), 3'(z)};
    MU_rd_addr = '0;
    MU_wr_data = d;
    MU_rden = 1'b1;
    MU_wr_data_valid = 1'b1;
    step();
    MU_rden = 1'b0;
    MU_wr_data_valid = 1'b0;
    ev = (idx >= 0) && (act_m[idx].size() > 0);
    ed = '0;
    if (ev) ed = act_m[idx][0];
    chk("rw_rd_valid", MU_rd_valid, ev);
    chk("rw_rd_data", MU_rd_data, ed);
    chk("rw_bad_cell_err", bad_cell_err, idx < 0);
    model_push(idx, d);
  endtask

  function automatic int rand_coord();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 6));
    return int'($urandom_range(1, 2));
  endfunction

  initial begin
    logic [PW-1:0] d1, d2, sd;
    int sidx;
    logic [SNC-1:0] sev;

    rst = 1'b1;
    rd_en = 0; rd_addr = '0; MU_rden = 0; MU_rd_cell = '0; MU_rd_addr = '0;
    MU_wr_data_valid = 0; MU_wr_data = '0; MU_dst_cell = '0; swap_req = 0;
    s_rd_en = 0; s_rd_addr = '0; s_MU_rden = 0; s_MU_rd_cell = '0; s_MU_rd_addr = '0;
    s_MU_wr_data_valid = 0; s_MU_wr_data = '0; s_MU_dst_cell = '0; s_swap_req = 0;
    clear_model();
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", MU_wr_ready, 1);
    chk("rst_busy", swap_busy, 0);
    chk("rst_done", swap_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bad_cell_err", bad_cell_err, 0);
    chk("rst_mu_valid", MU_rd_valid, 0);
    force_read(0);

    // Three writes to (1,1,1), swap, sweep addresses 0..3
    do_write(1, 1, 1, PW'(1));
    do_write(1, 1, 1, PW'(2));
    do_write(1, 1, 1, PW'(3));
    do_swap(1'b0, 0, 0, 0, '0);
    for (int a = 0; a < 4; a++) force_read(a);

    // Fill (5,5,5) past capacity
    for (int i = 0; i < 130; i++) do_write(5, 5, 5, rand_pos());
    chk("ovf_set", overflow, ovf_m);
    do_swap(1'b0, 0, 0, 0, '0);
    chk("ovf_cleared", overflow, ovf_m);
    force_read(127);
    mu_read(5, 5, 5, 127);
    mu_read(5, 5, 5, 0);

    // Out-of-range cells
    do_write(0, 2, 2, rand_pos());
    step();
    chk("bad_err_pulse_end", bad_cell_err, 0);
    do_write(6, 1, 1, rand_pos());
    step();
    chk("bad_err_pulse_end2", bad_cell_err, 0);
    mu_read(0, 1, 1, 0);
    mu_read(1, 1, 1, 0);

    // Write in the same cycle as swap_req
    d1 = rand_pos();
    do_swap(1'b1, 2, 3, 4, d1);
    mu_read(2, 3, 4, 0);
    force_read(0);

    // Write held during SWAP/DONE only lands after return to IDLE
    d2 = rand_pos();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    model_promote();
    MU_dst_cell = {3'd2, 3'd3, 3'd4};
    MU_wr_data = d2;
    MU_wr_data_valid = 1'b1;
    chk("hold_swap_ready", MU_wr_ready, 0);
    step();
    chk("hold_done_ready", MU_wr_ready, 0);
    chk("hold_done_pulse", swap_done, 1);
    step();
    chk("hold_idle_ready", MU_wr_ready, 1);
    step();
    MU_wr_data_valid = 1'b0;
    model_push(model_idx(2, 3, 4, X, Y, Z), d2);
    mu_read(2, 3, 4, 0);
    do_swap(1'b0, 0, 0, 0, '0);
    mu_read(2, 3, 4, 0);
    force_read(0);

    // Randomized mix
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_write(rand_coord(), rand_coord(), rand_coord(), rand_pos());
        5:             do_swap(1'($urandom_range(0, 1)), rand_coord(), rand_coord(), rand_coord(), rand_pos());
        6:             force_read(int'($urandom_range(0, 3)));
        7, 8:          mu_read(rand_coord(), rand_coord(), rand_coord(), int'($urandom_range(0, 3)));
        default:       rw_same(rand_coord(), rand_coord(), rand_coord(), rand_pos());
      endcase
    end
    chk("rand_overflow", overflow, ovf_m);
    do_swap(1'b0, 0, 0, 0, '0);
    force_read(0);
    force_read(1);

    // Reset asserted in SWAP
    do_write(1, 2, 1, rand_pos());
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("pre_rst_busy", swap_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", swap_busy, 0);
    chk("mid_rst_ready", MU_wr_ready, 1);
    chk("mid_rst_done", swap_done, 0);
    step();
    rst = 1'b0;
    clear_model();
    force_read(0);
    d1 = rand_pos();
    do_write(1, 1, 1, d1);
    do_swap(1'b0, 0, 0, 0, '0);
    mu_read(1, 1, 1, 0);
    mu_read(1, 1, 1, 1);

    // Small grid: cell (3,4,2)
    sd = rand_pos();
    sidx = model_idx(3, 4, 2, SX, SY, SZ);
    s_MU_dst_cell = {3'd3, 3'd4, 3'd2};
    s_MU_wr_data = sd;
    s_MU_wr_data_valid = 1'b1;
    chk("s_ready", s_MU_wr_ready, 1);
    step();
    s_MU_wr_data_valid = 1'b0;
    chk("s_good_cell", s_bad_cell_err, 0);
    s_MU_dst_cell = {3'd4, 3'd1, 3'd1};
    s_MU_wr_data_valid = 1'b1;
    step();
    s_MU_wr_data_valid = 1'b0;
    chk("s_bad_cell", s_bad_cell_err, 1);
    s_swap_req = 1'b1;
    step();
    s_swap_req = 1'b0;
    chk("s_swap_busy", s_swap_busy, 1);
    step();
    chk("s_swap_done", s_swap_done, 1);
    step();
    chk("s_overflow", s_overflow, 0);
    s_rd_en = 1'b1;
    s_rd_addr = '0;
    step();
    s_rd_en = 1'b0;
    sev = '0;
    sev[sidx] = 1'b1;
    chk("s_pos_valid", s_pos_valid_out, sev);
    chk("s_pos_data", s_pos_data_out[sidx*PW +: PW], sd);
    s_MU_rd_cell = {3'd3, 3'd4, 3'd2};
    s_MU_rd_addr = '0;
    s_MU_rden = 1'b1;
    step();
    s_MU_rden = 1'b0;
    chk("s_mu_valid", s_MU_rd_valid, 1);
    chk("s_mu_data", s_MU_rd_data, sd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
